// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU fetch front-end: channel FSM encoding and
// index-width sizing helper.
package gpu_pkg;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'b00,
    CH_WAITING  = 2'b01,
    CH_RELAYING = 2'b10
  } chan_state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_mask at or above
// pointer, wrapping around.
module rr_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int IDX_BITS = idx_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_mask,
  input  logic [IDX_BITS-1:0] pointer,
  output logic [IDX_BITS-1:0] grant_index,
  output logic                grant_valid
);

  logic [IDX_BITS:0] cand;

  always_comb begin
    grant_index = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // One extra bit keeps pointer+offset from overflowing before the wrap.
      cand = {1'b0, pointer} + (IDX_BITS+1)'(off);
      if (cand >= (IDX_BITS+1)'(NUM_REQ))
        cand = cand - (IDX_BITS+1)'(NUM_REQ);
      if (!grant_valid && req_mask[cand[IDX_BITS-1:0]]) begin
        grant_valid = 1'b1;
        grant_index = cand[IDX_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/prog_mem_controller.sv
// Program memory controller: multiplexes NUM_CONSUMERS fetcher ports onto
// NUM_CHANNELS memory ports with round-robin arbitration.
module prog_mem_controller
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);

  localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

  chan_state_t               state_reg   [NUM_CHANNELS];
  logic [IDX_BITS-1:0]       owner_reg   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]      mem_addr_reg[NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   mem_valid_reg;
  logic [NUM_CONSUMERS-1:0]  cons_ready_reg;
  logic [DATA_BITS-1:0]      cons_data_reg[NUM_CONSUMERS];
  logic [IDX_BITS-1:0]       ptr_reg, ptr_next;

  logic [ADDR_BITS-1:0]      cons_addr   [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]      mem_data    [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]  claimed;
  logic [NUM_CONSUMERS-1:0]  eligible;
  logic [IDX_BITS-1:0]       grant_index [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   grant_fire;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_cons
      assign cons_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = cons_data_reg[gi];
    end

    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_mem
      assign mem_data[gi] = mem_read_data[gi*DATA_BITS +: DATA_BITS];
      assign mem_read_address[gi*ADDR_BITS +: ADDR_BITS] = mem_addr_reg[gi];
    end
  endgenerate

  assign consumer_read_ready = cons_ready_reg;
  assign mem_read_valid      = mem_valid_reg;

  // A consumer stays claimed until its channel returns to IDLE, so a
  // release and a re-grant of the same consumer can never share a cycle.
  always_comb begin
    claimed = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_reg[c] != CH_IDLE)
        claimed[owner_reg[c]] = 1'b1;
    end
  end

  assign eligible = consumer_read_valid & ~claimed & ~cons_ready_reg;

  // Channels pick in ascending order; each one masks out what the lower
  // channels already took this cycle.
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [NUM_CONSUMERS-1:0] taken_in;
      logic [NUM_CONSUMERS-1:0] taken_out;
      logic [IDX_BITS-1:0]      pick;
      logic                     pick_valid;
      logic                     fire;

      if (gi == 0) begin : g_first
        assign taken_in = '0;
      end else begin : g_chain
        assign taken_in = g_chan[gi-1].taken_out;
      end

      rr_arbiter #(
        .NUM_REQ (NUM_CONSUMERS),
        .IDX_BITS(IDX_BITS)
      ) u_arb (
        .req_mask   (eligible & ~taken_in),
        .pointer    (ptr_reg),
        .grant_index(pick),
        .grant_valid(pick_valid)
      );

      assign fire      = pick_valid && (state_reg[gi] == CH_IDLE);
      assign taken_out = fire ? (taken_in | (NUM_CONSUMERS'(1) << pick)) : taken_in;
      assign grant_fire[gi]  = fire;
      assign grant_index[gi] = pick;
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant_fire[c])
        ptr_next = (grant_index[c] == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0
                                                                     : grant_index[c] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg        <= '0;
      mem_valid_reg  <= '0;
      cons_ready_reg <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_reg[c]    <= CH_IDLE;
        owner_reg[c]    <= '0;
        mem_addr_reg[c] <= '0;
      end
      for (int k = 0; k < NUM_CONSUMERS; k++)
        cons_data_reg[k] <= '0;
    end else begin
      ptr_reg <= ptr_next;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state_reg[c])
          CH_IDLE: begin
            if (grant_fire[c]) begin
              owner_reg[c]     <= grant_index[c];
              mem_addr_reg[c]  <= cons_addr[grant_index[c]];
              mem_valid_reg[c] <= 1'b1;
              state_reg[c]     <= CH_WAITING;
            end
          end
          CH_WAITING: begin
            // The read completes even if the fetcher has already dropped valid.
            if (mem_read_ready[c]) begin
              cons_data_reg[owner_reg[c]]  <= mem_data[c];
              cons_ready_reg[owner_reg[c]] <= 1'b1;
              mem_valid_reg[c]             <= 1'b0;
              state_reg[c]                 <= CH_RELAYING;
            end
          end
          CH_RELAYING: begin
            if (!consumer_read_valid[owner_reg[c]]) begin
              cons_ready_reg[owner_reg[c]] <= 1'b0;
              state_reg[c]                 <= CH_IDLE;
            end
          end
          default: begin
            state_reg[c] <= CH_IDLE;
          end
        endcase
      end
    end
  end

endmodule
